// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, constants and combinational helpers for the LSU
// memory stage.
//   lsu_size_e      - funct3 access-size encoding
//   lsu_ld_entry_t  - load tracking entry {rd, size, offset}
//   LSU_MASK_*      - byte-lane masks for byte/half/word stores
//   sext12, lsu_f3_defined, lsu_misaligned, lsu_wstrb, lsu_wdata,
//   lsu_ld_align    - address, strobe and load-data helpers
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_SZ_B  = 3'b000,
        LSU_SZ_H  = 3'b001,
        LSU_SZ_W  = 3'b010,
        LSU_SZ_BU = 3'b100,
        LSU_SZ_HU = 3'b101
    } lsu_size_e;

    // Register index width carried in a tracking entry; the top's REG_W
    // must match it.
    localparam int LSU_RD_W = 5;

    typedef struct packed {
        logic [LSU_RD_W-1:0] rd;
        lsu_size_e           size;
        logic [1:0]          offset;
    } lsu_ld_entry_t;

    localparam logic [3:0] LSU_MASK_B = 4'b0001;
    localparam logic [3:0] LSU_MASK_H = 4'b0011;
    localparam logic [3:0] LSU_MASK_W = 4'b1111;

    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

    // Unsigned sizes exist only for loads; everything else undefined is a NOP.
    function automatic logic lsu_f3_defined(input logic is_load, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: return 1'b1;
            3'b100, 3'b101:         return is_load;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lsu_wstrb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = LSU_MASK_B;
            2'b01:   m = LSU_MASK_H;
            default: m = LSU_MASK_W;
        endcase
        return m << off;
    endfunction

    function automatic logic [31:0] lsu_wdata(input logic [31:0] data, input logic [1:0] off);
        return data << {off, 3'b000};
    endfunction

    function automatic logic [31:0] lsu_ld_align(input logic [31:0] rdata,
                                                 input lsu_size_e size,
                                                 input logic [1:0] off);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            LSU_SZ_B:  return {{24{sh[7]}}, sh[7:0]};
            LSU_SZ_BU: return {24'b0, sh[7:0]};
            LSU_SZ_H:  return {{16{sh[15]}}, sh[15:0]};
            LSU_SZ_HU: return {16'b0, sh[15:0]};
            default:   return sh;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ld_fifo.sv
// lsu_ld_fifo: DEPTH-entry in-order FIFO tracking outstanding loads.
//   clk, rst     - clock, async active-high reset (clears pointers/count)
//   push, din    - enqueue an entry (ignored when full)
//   pop, dout    - dequeue the head entry (ignored when empty); dout is head
//   count        - number of entries held
//   full, empty  - status flags derived from count
module lsu_ld_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   din,
    input  logic                     pop,
    output entry_t                   dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store memory stage for the VLIW LSU slot.
//   op_*         - decoded LSU op from issue (valid/ready)
//   mem_req_*    - word-aligned memory request (valid/ready), lane-shifted stores
//   mem_rsp_*    - in-order load data, one beat per load, none for stores
//   wb_*         - aligned/extended load writeback, one-cycle pulse
//   misalign_*   - misaligned-access exception pulse with the effective address
//   idle         - no request held and no load in flight
//   dbg_state    - request slot FSM state (0 idle, 1 hold)
//
// Handshakes: a transfer happens on a rising edge where valid && ready; while
// valid is high and ready low, the offering side keeps every field stable.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_is_load,
    input  logic              op_is_nop,
    input  logic [2:0]        op_funct3,
    input  logic [REG_W-1:0]  op_rd,
    input  logic [11:0]       op_imm,
    input  logic [31:0]       op_rs1_data,
    input  logic [31:0]       op_rs2_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [31:0]       mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_rdata,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [31:0]       wb_data,
    output logic              misalign_valid,
    output logic [ADDR_W-1:0] misalign_addr,
    output logic              idle,
    output logic [0:0]        dbg_state
);
    localparam logic [0:0] REQ_IDLE = 1'b0;
    localparam logic [0:0] REQ_HOLD = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              mis_valid_q, mis_valid_d;
    logic [ADDR_W-1:0] mis_addr_q, mis_addr_d;
    logic              wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d;

    logic [31:0]          imm_ext;
    logic [ADDR_W-1:0]    ea;
    logic                 accept, is_nop, is_mis, do_mem, do_push;
    lsu_ld_entry_t        push_entry, head_entry;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                 fifo_full, fifo_empty;

    assign imm_ext = sext12(op_imm);
    assign ea      = op_rs1_data[ADDR_W-1:0] + imm_ext[ADDR_W-1:0];

    // Undefined funct3 encodings collapse into NOPs.
    assign is_nop  = op_is_nop || !lsu_f3_defined(op_is_load, op_funct3);
    assign is_mis  = !is_nop && lsu_misaligned(op_funct3, ea[1:0]);
    assign accept  = op_valid && op_ready;
    assign do_mem  = accept && !is_nop && !is_mis;
    assign do_push = do_mem && op_is_load;

    // Full blocks every op class, stores included, using the registered count.
    assign op_ready = ((state_q == REQ_IDLE) || mem_req_ready) && !fifo_full;

    assign push_entry.rd     = LSU_RD_W'(op_rd);
    assign push_entry.size   = lsu_size_e'(op_funct3);
    assign push_entry.offset = ea[1:0];

    lsu_ld_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (lsu_ld_entry_t)
    ) u_ld_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .din   (push_entry),
        .pop   (mem_rsp_valid),
        .dout  (head_entry),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        mis_valid_d = accept && is_mis;
        mis_addr_d  = mis_addr_q;
        // A response with nothing in flight is dropped.
        wb_valid_d  = mem_rsp_valid && !fifo_empty;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;

        if ((state_q == REQ_HOLD) && mem_req_ready) state_d = REQ_IDLE;

        // A new op reloads the slot, also in the same cycle as a handshake.
        if (do_mem) begin
            state_d = REQ_HOLD;
            addr_d  = {ea[ADDR_W-1:2], 2'b00};
            we_d    = !op_is_load;
            wdata_d = op_is_load ? 32'h0 : lsu_wdata(op_rs2_data, ea[1:0]);
            wstrb_d = op_is_load ? 4'h0 : lsu_wstrb(op_funct3, ea[1:0]);
        end

        if (accept && is_mis) mis_addr_d = ea;

        if (wb_valid_d) begin
            wb_rd_d   = REG_W'(head_entry.rd);
            wb_data_d = lsu_ld_align(mem_rsp_rdata, head_entry.size, head_entry.offset);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= REQ_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            mis_valid_q <= 1'b0;
            mis_addr_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            mis_valid_q <= mis_valid_d;
            mis_addr_q  <= mis_addr_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign mem_req_valid  = (state_q == REQ_HOLD);
    assign mem_req_addr   = addr_q;
    assign mem_req_we     = we_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wstrb  = wstrb_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign misalign_valid = mis_valid_q;
    assign misalign_addr  = mis_addr_q;
    assign idle           = (state_q == REQ_IDLE) && (fifo_count == '0);
    assign dbg_state      = state_q;

endmodule
